// File: rtl/vend_coin_scheduler.sv
// Round-robin front end that shares one vending core between NREQ coin sources,
// locking the core to a single requester per purchase and supervising the core's response.
module vend_coin_scheduler #(
  parameter int NREQ  = 2,
  parameter int PRICE = 3,
  parameter int TMO   = 15,
  localparam int OW   = $clog2(NREQ),
  localparam int CW   = $clog2(PRICE + 2),
  localparam int TW   = ($clog2(TMO + 1) < 4) ? 4 : $clog2(TMO + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_coin,
  output logic [NREQ-1:0]   req_ready,
  output logic [1:0]        vm_coin,
  input  logic              vm_product,
  input  logic              vm_change,
  output logic [OW-1:0]     owner,
  output logic              busy,
  output logic              dispensed,
  output logic              change_out,
  output logic              err_tmo,
  output logic              err_proto,
  input  logic              err_clr
);

  typedef enum logic [1:0] {IDLE, SESSION, DISPENSE, ERR} state_t;

  state_t          state_q;
  logic [OW-1:0]   rr_ptr_q, owner_q;
  logic [CW-1:0]   credit_q;
  logic [TW-1:0]   tmo_q;
  logic            exp_chg_q, err_tmo_q, err_proto_q;
  logic [1:0]      vm_coin_q;

  logic [OW-1:0]   grant, sel;
  logic            grant_vld, acc;
  logic [1:0]      coin, val;
  logic [CW:0]     credit_d;

  // Unit value of a coin code; 00 and 11 carry no credit.
  function automatic logic [1:0] coin_val(input logic [1:0] c);
    return (c == 2'b01 || c == 2'b10) ? c : 2'b00;
  endfunction

  // Descending search so the requester closest to rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        grant_vld = 1'b1;
        grant     = OW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    sel      = (state_q == SESSION) ? owner_q : grant;
    acc      = !rst && (((state_q == IDLE) && grant_vld) ||
                        ((state_q == SESSION) && req_valid[owner_q]));
    coin     = req_coin[2*int'(sel) +: 2];
    val      = coin_val(coin);
    credit_d = ((state_q == SESSION) ? {1'b0, credit_q} : '0) + (CW+1)'(val);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      credit_q    <= '0;
      tmo_q       <= '0;
      exp_chg_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_proto_q <= 1'b0;
      vm_coin_q   <= 2'b00;
    end else begin
      vm_coin_q <= (acc && val != 2'b00) ? coin : 2'b00;
      if (err_clr) begin
        err_tmo_q   <= 1'b0;
        err_proto_q <= 1'b0;
      end
      if (vm_product && state_q != DISPENSE) err_proto_q <= 1'b1;

      case (state_q)
        IDLE, SESSION: begin
          if (acc && val != 2'b00) begin
            if (state_q == IDLE) owner_q <= grant;
            credit_q <= credit_d[CW-1:0];
            if (credit_d >= (CW+1)'(PRICE)) begin
              state_q   <= DISPENSE;
              tmo_q     <= '0;
              exp_chg_q <= (credit_d != (CW+1)'(PRICE));
            end else begin
              state_q <= SESSION;
            end
          end
        end
        DISPENSE: begin
          if (vm_product) begin
            if (vm_change != exp_chg_q) err_proto_q <= 1'b1;
            credit_q <= '0;
            rr_ptr_q <= (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            state_q  <= IDLE;
          end else if (tmo_q == TW'(TMO - 1)) begin
            err_tmo_q <= 1'b1;
            state_q   <= ERR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ERR: begin
          if (err_clr) begin
            credit_q <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = acc ? (NREQ'(1) << sel) : '0;
  assign vm_coin    = vm_coin_q;
  assign owner      = owner_q;
  assign busy       = (state_q == SESSION) || (state_q == DISPENSE);
  assign dispensed  = !rst && (state_q == DISPENSE) && vm_product;
  assign change_out = !rst && (state_q == DISPENSE) && vm_product && vm_change;
  assign err_tmo    = err_tmo_q;
  assign err_proto  = err_proto_q;

endmodule

// File: tb/tb_vend_coin_scheduler.sv
// Directed bench for vend_coin_scheduler: per-cycle vector table plus timeout and reset sequences.
module tb_vend_coin_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [3:0] req_coin;
  logic [1:0] req_ready;
  logic [1:0] vm_coin;
  logic       vm_product, vm_change;
  logic [0:0] owner;
  logic       busy, dispensed, change_out, err_tmo, err_proto, err_clr;

  vend_coin_scheduler #(.NREQ(2), .PRICE(3), .TMO(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_coin(req_coin), .req_ready(req_ready),
    .vm_coin(vm_coin), .vm_product(vm_product), .vm_change(vm_change),
    .owner(owner), .busy(busy), .dispensed(dispensed), .change_out(change_out),
    .err_tmo(err_tmo), .err_proto(err_proto), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;   logic [3:0] c;   logic p;   logic ch;  logic clr;
    logic [1:0] rdy; logic [1:0] vmc; logic bsy; logic own; logic dsp;
    logic cho;       logic etmo;      logic eprt;
  } vec_t;

  vec_t vecs[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] c, input logic p,
                       input logic ch, input logic clr);
    req_valid  = v;
    req_coin   = c;
    vm_product = p;
    vm_change  = ch;
    err_clr    = clr;
  endtask

  initial begin
    //              v     c     p  ch clr  rdy  vmc  bsy own dsp cho tmo prt
    vecs.push_back('{2'b00,4'b0000,0,0,0, 2'b00,2'b00,0,0,0,0,0,0}); // idle after reset
    vecs.push_back('{2'b01,4'b0001,0,0,0, 2'b01,2'b00,0,0,0,0,0,0}); // req0 coin 01
    vecs.push_back('{2'b01,4'b0010,0,0,0, 2'b01,2'b01,1,0,0,0,0,0}); // req0 coin 10
    vecs.push_back('{2'b00,4'b0000,0,0,0, 2'b00,2'b10,1,0,0,0,0,0}); // dispense wait
    vecs.push_back('{2'b00,4'b0000,1,0,0, 2'b00,2'b00,1,0,1,0,0,0}); // product, no change
    vecs.push_back('{2'b00,4'b0000,0,0,0, 2'b00,2'b00,0,0,0,0,0,0});
    vecs.push_back('{2'b11,4'b0101,0,0,0, 2'b10,2'b00,0,0,0,0,0,0}); // rr_ptr=1: req1 wins
    vecs.push_back('{2'b11,4'b1010,0,0,0, 2'b10,2'b01,1,1,0,0,0,0}); // req0 held off
    vecs.push_back('{2'b01,4'b0010,1,0,0, 2'b00,2'b10,1,1,1,0,0,0}); // dispense blocks coins
    vecs.push_back('{2'b01,4'b0010,0,0,0, 2'b01,2'b00,0,1,0,0,0,0}); // req0 granted next
    vecs.push_back('{2'b01,4'b0010,0,0,0, 2'b01,2'b10,1,0,0,0,0,0}); // credit 4 -> change
    vecs.push_back('{2'b00,4'b0000,1,1,0, 2'b00,2'b10,1,0,1,1,0,0}); // product + change
    vecs.push_back('{2'b00,4'b0000,0,0,0, 2'b00,2'b00,0,0,0,0,0,0});
    vecs.push_back('{2'b00,4'b0000,1,0,0, 2'b00,2'b00,0,0,0,0,0,0}); // stray product in IDLE
    vecs.push_back('{2'b00,4'b0000,0,0,1, 2'b00,2'b00,0,0,0,0,0,1}); // err_clr
    vecs.push_back('{2'b10,4'b0100,0,0,0, 2'b10,2'b00,0,0,0,0,0,0}); // req1 coin 01
    vecs.push_back('{2'b10,4'b1100,0,0,0, 2'b10,2'b01,1,1,0,0,0,0}); // coin 11 consumed
    vecs.push_back('{2'b00,4'b0000,0,0,0, 2'b00,2'b00,1,1,0,0,0,0}); // nothing forwarded
    vecs.push_back('{2'b10,4'b0100,0,0,0, 2'b10,2'b00,1,1,0,0,0,0}); // credit 2
    vecs.push_back('{2'b10,4'b0100,0,0,0, 2'b10,2'b01,1,1,0,0,0,0}); // credit 3
    vecs.push_back('{2'b00,4'b0000,1,1,0, 2'b00,2'b01,1,1,1,1,0,0}); // unexpected change
    vecs.push_back('{2'b00,4'b0000,0,0,1, 2'b00,2'b00,0,1,0,0,0,1}); // proto flagged
    vecs.push_back('{2'b01,4'b0000,0,0,0, 2'b01,2'b00,0,1,0,0,0,0}); // coin 00 dropped
    vecs.push_back('{2'b00,4'b0000,0,0,0, 2'b00,2'b00,0,1,0,0,0,0}); // still IDLE

    rst = 1'b1;
    drive(2'b01, 4'b0001, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst ready", 8'(req_ready), 8'h00);
    chk("rst vm_coin", 8'(vm_coin), 8'h00);
    chk("rst busy", 8'(busy), 8'h00);
    drive(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].c, vecs[i].p, vecs[i].ch, vecs[i].clr);
      #2;
      chk($sformatf("row%0d ready", i),      8'(req_ready),  8'(vecs[i].rdy));
      chk($sformatf("row%0d vm_coin", i),    8'(vm_coin),    8'(vecs[i].vmc));
      chk($sformatf("row%0d busy", i),       8'(busy),       8'(vecs[i].bsy));
      chk($sformatf("row%0d owner", i),      8'(owner),      8'(vecs[i].own));
      chk($sformatf("row%0d dispensed", i),  8'(dispensed),  8'(vecs[i].dsp));
      chk($sformatf("row%0d change_out", i), 8'(change_out), 8'(vecs[i].cho));
      chk($sformatf("row%0d err_tmo", i),    8'(err_tmo),    8'(vecs[i].etmo));
      chk($sformatf("row%0d err_proto", i),  8'(err_proto),  8'(vecs[i].eprt));
      tick();
    end

    // Timeout: core stays silent for TMO cycles in DISPENSE.
    drive(2'b01, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    drive(2'b01, 4'b0010, 1'b0, 1'b0, 1'b0);
    tick();
    drive(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    #2;
    chk("tmo enter busy", 8'(busy), 8'h01);
    for (int k = 1; k <= 14; k++) begin
      tick();
      #2;
      chk($sformatf("tmo wait%0d err_tmo", k), 8'(err_tmo), 8'h00);
      chk($sformatf("tmo wait%0d busy", k), 8'(busy), 8'h01);
    end
    tick();
    drive(2'b01, 4'b0001, 1'b0, 1'b0, 1'b0);
    #2;
    chk("tmo err_tmo", 8'(err_tmo), 8'h01);
    chk("tmo busy", 8'(busy), 8'h00);
    chk("err ready", 8'(req_ready), 8'h00);
    drive(2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    drive(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    #2;
    chk("clr err_tmo", 8'(err_tmo), 8'h00);
    chk("clr busy", 8'(busy), 8'h00);
    drive(2'b01, 4'b0001, 1'b0, 1'b0, 1'b0);
    #1;
    chk("clr idle ready", 8'(req_ready), 8'h01);

    // Reset mid-session with credit 2.
    drive(2'b01, 4'b0010, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    chk("pre-rst busy", 8'(busy), 8'h01);
    chk("pre-rst vm_coin", 8'(vm_coin), 8'h02);
    rst = 1'b1;
    #1;
    chk("mid-rst busy", 8'(busy), 8'h00);
    chk("mid-rst vm_coin", 8'(vm_coin), 8'h00);
    chk("mid-rst ready", 8'(req_ready), 8'h00);
    chk("mid-rst dispensed", 8'(dispensed), 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(2'b01, 4'b0010, 1'b0, 1'b0, 1'b0);
    tick();
    drive(2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
    #2;
    chk("post-rst credit 2 session", 8'(req_ready), 8'h01);
    chk("post-rst vm_coin", 8'(vm_coin), 8'h02);
    tick();
    drive(2'b01, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    drive(2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
    #2;
    chk("post-rst dispensed", 8'(dispensed), 8'h01);
    chk("post-rst change_out", 8'(change_out), 8'h00);
    tick();
    drive(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    #2;
    chk("post-rst idle busy", 8'(busy), 8'h00);
    chk("post-rst err_proto", 8'(err_proto), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
